btb_2way: RTL and testbench
===========================

// Module: btb_2way
// PURPOSE
//  2-way set-associative Branch Target Buffer feeding the fetch-stage PC mux.
//  Lookup with PC_F in the same cycle as instruction fetch; returns a cached target
//  for the next-PC select alongside the Gshare direction bit. Trained from EX with
//  the resolved PC and target of taken branches/jumps.
// PARAMETERS
//  WIDTH     32  PC / target width
//  SETS      16  number of sets (power of 2, >=2)
//  IDX_W     $clog2(SETS)  index width (derived, localparam)
//  TAG_W     WIDTH-IDX_W-2  tag width (derived, localparam)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous, active-low reset
//  lookup_en_F    in   1      fetch lookup valid (branch/jump decoded in F)
//  PC_F           in   WIDTH  fetch PC
//  hit_F          out  1      lookup hit (combinational)
//  target_F       out  WIDTH  cached target; 0 when hit_F=0
//  update_en_EX   in   1      EX training request
//  PC_EX          in   WIDTH  PC of resolved branch/jump
//  target_EX      in   WIDTH  resolved target
//  taken_EX       in   1      resolved taken
//  flush_all      in   1      synchronous invalidate of every entry
//  hits_cnt       out  16     saturating count of lookups that hit
//  lookups_cnt    out  16     saturating count of lookups
// BEHAVIOUR
//  - Index = PC[IDX_W+1:2]; tag = PC[WIDTH-1:IDX_W+2]; PC[1:0] ignored.
//  - Per set: 2 ways x {valid, tag, target}; one LRU bit (points to victim way).
//  - Reset (rst=0, async): all valid=0, all LRU=0, both counters=0; hence hit_F=0,
//    target_F=0. Tag/target arrays need no reset.
//  - Lookup: zero latency. hit_F = lookup_en_F & (way0 match | way1 match).
//    Both ways matching cannot occur (update never duplicates); if it does, way0 wins.
//    Lookup never changes LRU. lookup_en_F=0 -> hit_F=0, target_F=0.
//  - Update (update_en_EX=1, written at clock edge):
//    * tag hits way w, taken_EX=1: target[w]<=target_EX; LRU<=~w.
//    * tag hits way w, taken_EX=0: no change (direction is the predictor's job).
//    * miss, taken_EX=1: allocate: way0 if invalid, else way1 if invalid, else LRU
//      way; write valid=1, tag, target; LRU<=~allocated way.
//    * miss, taken_EX=0: no change.
//  - Same-cycle lookup and update to same set: lookup returns pre-update contents
//    (no bypass); new contents visible next cycle.
//  - flush_all=1: all valid<=0, LRU<=0 next edge; takes priority over a coincident
//    update (update dropped). Counters not cleared by flush.
//  - Counters: lookups_cnt+=1 per cycle with lookup_en_F; hits_cnt+=1 when hit_F;
//    both saturate at 16'hFFFF (no wrap).
//  - Reset asserted mid-operation clears state immediately regardless of clk.
// TESTING
//  1 Reset, lookup_en_F=1 PC_F=0x100 -> hit_F=0, target_F=0, lookups_cnt=1 next cycle.
//  2 Update PC_EX=0x100 tgt=0x80 taken=1; next cycle lookup 0x100 -> hit_F=1,
//    target_F=0x80; lookup 0x140 (same set, SETS=16) -> hit_F=0.
//  3 Fill set 0 with 0x100->0x10 (way0), 0x200->0x20 (way1), update 0x100 taken,
//    then allocate 0x300->0x30 -> evicts 0x200; 0x100 and 0x300 hit, 0x200 misses.
//  4 Same cycle: update 0x400->0x44 taken and lookup 0x400 -> hit_F=0 that cycle,
//    hit_F=1 target 0x44 the next; update with taken=0 for unknown PC -> no allocate.
//  5 flush_all=1 together with update 0x500 -> next cycle all lookups miss,
//    counters retained; drive 70000 hitting lookups -> hits_cnt=lookups_cnt=0xFFFF.
//  6 Pulse rst low between clock edges after training -> hit_F drops to 0 at once.

Source files
------------

// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer for the fetch-stage next-PC mux.
// Lookup is combinational on PC_F; training arrives from EX and is written on
// the rising clock edge. One LRU bit per set names the victim way.
// Ports:
//   clk, rst (async active-low)
//   lookup_en_F, PC_F           -> hit_F, target_F (combinational)
//   update_en_EX, PC_EX, target_EX, taken_EX  (training from EX)
//   flush_all                   synchronous invalidate of every entry
//   hits_cnt, lookups_cnt       saturating 16-bit statistics (registered)
module btb_2way #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SETS  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_en_F,
  input  logic [WIDTH-1:0] PC_F,
  output logic             hit_F,
  output logic [WIDTH-1:0] target_F,
  input  logic             update_en_EX,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic [WIDTH-1:0] target_EX,
  input  logic             taken_EX,
  input  logic             flush_all,
  output logic [15:0]      hits_cnt,
  output logic [15:0]      lookups_cnt
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = WIDTH - IDX_W - 2;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Valid and LRU state is reset; tag/target arrays are qualified by valid.
  logic [SETS-1:0]  vld0_q, vld1_q, lru_q;
  logic [TAG_W-1:0] tag0_q [SETS];
  logic [TAG_W-1:0] tag1_q [SETS];
  logic [WIDTH-1:0] tgt0_q [SETS];
  logic [WIDTH-1:0] tgt1_q [SETS];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_m0, lk_m1;
  logic             up_m0, up_m1;
  logic             wr_en;
  logic             wr_way;

  // Byte offset bits never take part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PC_F[1:0], PC_EX[1:0]};

  // Fetch-side lookup; way0 wins should both ways ever match.
  always_comb begin
    lk_idx   = PC_F[IDX_W+1:2];
    lk_tag   = PC_F[WIDTH-1:IDX_W+2];
    lk_m0    = vld0_q[lk_idx] && (tag0_q[lk_idx] == lk_tag);
    lk_m1    = vld1_q[lk_idx] && (tag1_q[lk_idx] == lk_tag);
    hit_F    = lookup_en_F && (lk_m0 || lk_m1);
    target_F = '0;
    if (lookup_en_F) begin
      if (lk_m0)      target_F = tgt0_q[lk_idx];
      else if (lk_m1) target_F = tgt1_q[lk_idx];
    end
  end

  // EX-side training: choose the way to write, or none.
  always_comb begin
    up_idx = PC_EX[IDX_W+1:2];
    up_tag = PC_EX[WIDTH-1:IDX_W+2];
    up_m0  = vld0_q[up_idx] && (tag0_q[up_idx] == up_tag);
    up_m1  = vld1_q[up_idx] && (tag1_q[up_idx] == up_tag);
    wr_en  = update_en_EX && taken_EX && !flush_all;
    wr_way = 1'b0;
    if (up_m0)               wr_way = 1'b0;
    else if (up_m1)          wr_way = 1'b1;
    else if (!vld0_q[up_idx]) wr_way = 1'b0;
    else if (!vld1_q[up_idx]) wr_way = 1'b1;
    else                     wr_way = lru_q[up_idx];
  end

  // Valid / LRU state; flush beats a coincident update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld0_q <= '0;
      vld1_q <= '0;
      lru_q  <= '0;
    end else if (flush_all) begin
      vld0_q <= '0;
      vld1_q <= '0;
      lru_q  <= '0;
    end else if (wr_en) begin
      if (wr_way) vld1_q[up_idx] <= 1'b1;
      else        vld0_q[up_idx] <= 1'b1;
      lru_q[up_idx] <= ~wr_way;
    end
  end

  // Tag / target payload arrays.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_way) begin
        tag1_q[up_idx] <= up_tag;
        tgt1_q[up_idx] <= target_EX;
      end else begin
        tag0_q[up_idx] <= up_tag;
        tgt0_q[up_idx] <= target_EX;
      end
    end
  end

  // Saturating lookup / hit statistics; untouched by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_cnt    <= '0;
      lookups_cnt <= '0;
    end else begin
      if (lookup_en_F && (lookups_cnt != CNT_MAX)) lookups_cnt <= lookups_cnt + 16'd1;
      if (hit_F && (hits_cnt != CNT_MAX))          hits_cnt    <= hits_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_btb_2way.sv
// Directed bench for btb_2way: lookup/train/evict/flush/saturation/async reset.
module tb_btb_2way;

  logic        clk;
  logic        rst;
  logic        lookup_en_F;
  logic [31:0] PC_F;
  logic        hit_F;
  logic [31:0] target_F;
  logic        update_en_EX;
  logic [31:0] PC_EX;
  logic [31:0] target_EX;
  logic        taken_EX;
  logic        flush_all;
  logic [15:0] hits_cnt;
  logic [15:0] lookups_cnt;

  int          vectors;
  int          miscompares;
  logic [15:0] exp_lk;
  logic [15:0] exp_ht;
  logic        exp_hit_now;

  btb_2way #(.WIDTH(32), .SETS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_en_F  (lookup_en_F),
    .PC_F         (PC_F),
    .hit_F        (hit_F),
    .target_F     (target_F),
    .update_en_EX (update_en_EX),
    .PC_EX        (PC_EX),
    .target_EX    (target_EX),
    .taken_EX     (taken_EX),
    .flush_all    (flush_all),
    .hits_cnt     (hits_cnt),
    .lookups_cnt  (lookups_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check hit_F/target_F for the lookup currently on the inputs.
  task automatic chk(input string tag, input logic eh, input logic [31:0] et);
    exp_hit_now = eh && lookup_en_F;
    vectors++;
    assert (hit_F === eh) else begin
      miscompares++;
      $error("FAIL %s hit_F observed=%0b expected=%0b", tag, hit_F, eh);
    end
    vectors++;
    assert (target_F === et) else begin
      miscompares++;
      $error("FAIL %s target_F observed=%h expected=%h", tag, target_F, et);
    end
  endtask

  task automatic chk_cnt(input string tag);
    vectors++;
    assert (lookups_cnt === exp_lk) else begin
      miscompares++;
      $error("FAIL %s lookups_cnt observed=%h expected=%h", tag, lookups_cnt, exp_lk);
    end
    vectors++;
    assert (hits_cnt === exp_ht) else begin
      miscompares++;
      $error("FAIL %s hits_cnt observed=%h expected=%h", tag, hits_cnt, exp_ht);
    end
  endtask

  // Advance one clock; expected counters follow the lookup just checked.
  task automatic tick();
    if (lookup_en_F) begin
      if (exp_lk != 16'hFFFF) exp_lk = exp_lk + 16'd1;
      if (exp_hit_now && exp_ht != 16'hFFFF) exp_ht = exp_ht + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_en_F = 1'b1;
    PC_F        = pc;
    #1;
  endtask

  task automatic idle_lk();
    lookup_en_F = 1'b0;
    PC_F        = '0;
    exp_hit_now = 1'b0;
  endtask

  // Train for one edge with no lookup in flight.
  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    idle_lk();
    update_en_EX = 1'b1;
    PC_EX        = pc;
    target_EX    = tgt;
    taken_EX     = tk;
    tick();
    update_en_EX = 1'b0;
    taken_EX     = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    exp_lk = '0; exp_ht = '0; exp_hit_now = 1'b0;
    rst = 1'b0;
    lookup_en_F = 1'b0; PC_F = '0;
    update_en_EX = 1'b0; PC_EX = '0; target_EX = '0; taken_EX = 1'b0;
    flush_all = 1'b0;

    // 1: reset state, first lookup misses and is counted
    #3;
    chk_cnt("reset_cnt");
    look(32'h100);
    chk("reset_lookup", 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    look(32'h100);
    chk("t1_miss", 1'b0, 32'h0);
    tick();
    chk_cnt("t1_cnt");

    // 2: train and hit; same-set other tag misses; lookup disabled gives 0
    train(32'h100, 32'h80, 1'b1);
    look(32'h100);
    chk("t2_hit", 1'b1, 32'h80);
    tick();
    look(32'h140);
    chk("t2_same_set_miss", 1'b0, 32'h0);
    tick();
    idle_lk(); #1;
    chk("t2_lookup_off", 1'b0, 32'h0);
    chk_cnt("t2_cnt");

    // 3: LRU victim selection in set 0
    train(32'h100, 32'h10, 1'b1);
    train(32'h200, 32'h20, 1'b1);
    train(32'h100, 32'h10, 1'b1);
    train(32'h300, 32'h30, 1'b1);
    look(32'h100); chk("t3_keep_100", 1'b1, 32'h10); tick();
    look(32'h300); chk("t3_new_300",  1'b1, 32'h30); tick();
    look(32'h200); chk("t3_evict_200", 1'b0, 32'h0); tick();

    // 4: no bypass on same-cycle update/lookup; 0x400 evicts LRU way0 (0x100)
    update_en_EX = 1'b1; PC_EX = 32'h400; target_EX = 32'h44; taken_EX = 1'b1;
    look(32'h400);
    chk("t4_same_cycle", 1'b0, 32'h0);
    tick();
    update_en_EX = 1'b0; taken_EX = 1'b0;
    #1;
    chk("t4_next_cycle", 1'b1, 32'h44);
    tick();
    train(32'h600, 32'h66, 1'b0);
    look(32'h600); chk("t4_no_alloc", 1'b0, 32'h0); tick();
    train(32'h300, 32'h99, 1'b0);
    look(32'h300); chk("t4_nt_hit_kept", 1'b1, 32'h30); tick();
    look(32'h100); chk("t4_100_evicted", 1'b0, 32'h0); tick();
    idle_lk(); #1;
    chk_cnt("t4_cnt");

    // 5: flush beats coincident update; counters survive; saturation
    flush_all = 1'b1;
    train(32'h500, 32'h55, 1'b1);
    flush_all = 1'b0;
    look(32'h500); chk("t5_flush_500", 1'b0, 32'h0); tick();
    look(32'h400); chk("t5_flush_400", 1'b0, 32'h0); tick();
    look(32'h300); chk("t5_flush_300", 1'b0, 32'h0); tick();
    idle_lk(); #1;
    chk_cnt("t5_cnt_kept");
    train(32'h500, 32'h55, 1'b1);
    for (int i = 0; i < 66000; i++) begin
      look(32'h500);
      exp_hit_now = 1'b1;
      tick();
    end
    chk("t5_sat_hit", 1'b1, 32'h55);
    idle_lk(); #1;
    chk_cnt("t5_sat_model");
    vectors++;
    assert (lookups_cnt === 16'hFFFF) else begin
      miscompares++;
      $error("FAIL t5_lk_sat observed=%h expected=ffff", lookups_cnt);
    end
    vectors++;
    assert (hits_cnt === 16'hFFFF) else begin
      miscompares++;
      $error("FAIL t5_ht_sat observed=%h expected=ffff", hits_cnt);
    end

    // 6: async reset between edges drops everything at once
    look(32'h500);
    chk("t6_before", 1'b1, 32'h55);
    #1;
    rst = 1'b0;
    #1;
    exp_lk = '0; exp_ht = '0;
    chk("t6_during", 1'b0, 32'h0);
    chk_cnt("t6_cnt_cleared");
    idle_lk();
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    look(32'h500); chk("t6_after", 1'b0, 32'h0); tick();
    idle_lk(); #1;
    chk_cnt("t6_cnt_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
